// File: rtl/shreg_ctrl_pkg.sv
// rtl/shreg_ctrl_pkg.sv - shared types and constants for the serial header/payload controller
package shreg_ctrl_pkg;

  // Number of header bits shifted into the external shift register (2 bits d, 4 bits n).
  localparam int HDR_LEN_DEF = 6;

  // Number of destination ports addressed by d.
  localparam int NPORTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    HDR,
`ifdef SHREG_CTRL_PARITY_EN
    PAR,
`endif
    PAY,
    DONE
  } state_t;

  function automatic logic [NPORTS-1:0] port_onehot(input logic [1:0] p);
    port_onehot = NPORTS'(1) << p;
  endfunction

endpackage

// File: rtl/shreg_ctrl_down_cnt4.sv
// rtl/shreg_ctrl_down_cnt4.sv - 4-bit loadable down counter with zero flag
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (cnt -> 0)
//   load       load load_val (has priority over dec)
//   load_val   value to load
//   dec        decrement by one
//   cnt        current count
//   zero       cnt == 0
module down_cnt4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/shreg_ctrl.sv
// rtl/shreg_ctrl.sv - serial frame controller driving an external header shift register
//
// Frame: start bit, HDR_LEN header bits (d[1:0] then n[3:0], MSB first),
// optional even-parity bit, then n payload bits routed to port d.
// Optional build macro: SHREG_CTRL_PARITY_EN adds the PAR state and the perr port.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   serIn      serial line (idle low), also feeds the external shift register
//   n, d       payload length / destination from the external shift register
//   shen, init shift enable / synchronous clear to the shift register
//   serOut     serOut[d] follows serIn during payload, other bits 0
//   valid      one-hot payload strobe
//   done       one-cycle end-of-frame pulse
//   perr       one-cycle parity error pulse (SHREG_CTRL_PARITY_EN only)
//   busy       high whenever not IDLE
module shreg_ctrl
  import shreg_ctrl_pkg::*;
#(
  parameter int HDR_LEN = HDR_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  input  logic [3:0]        n,
  input  logic [1:0]        d,
  output logic              shen,
  output logic              init,
  output logic [NPORTS-1:0] serOut,
  output logic [NPORTS-1:0] valid,
  output logic              done,
`ifdef SHREG_CTRL_PARITY_EN
  output logic              perr,
`endif
  output logic              busy
);

  state_t     state;
  logic [3:0] n_r;
  logic [1:0] d_r;
  logic       cap;       // first cycle after HDR: shift register is settled
  logic       cnt_load;
  logic [3:0] cnt_val;
  logic       cnt_dec;
  logic [3:0] cnt;
  logic       cnt_zero;

`ifndef SHREG_CTRL_PARITY_EN
  // The last header bit is shifted in on the same edge that leaves HDR, so the
  // exit decision uses the post-shift view of n/d.
  logic [3:0] hdr_n;
  logic [1:0] hdr_d;
  assign hdr_n = {n[2:0], serIn};
  assign hdr_d = {d[0], n[3]};
`endif

  down_cnt4 u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = 4'd0;
    cnt_dec  = 1'b0;
    case (state)
      INIT: begin
        cnt_load = 1'b1;
        cnt_val  = 4'(HDR_LEN - 1);
      end
      HDR: begin
        if (cnt_zero) begin
`ifndef SHREG_CTRL_PARITY_EN
          cnt_load = 1'b1;
          cnt_val  = hdr_n - 4'd1;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef SHREG_CTRL_PARITY_EN
      PAR: begin
        cnt_load = 1'b1;
        cnt_val  = n - 4'd1;
      end
`endif
      PAY:     cnt_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_r   <= 4'd0;
      d_r   <= 2'd0;
      cap   <= 1'b0;
      init  <= 1'b0;
      shen  <= 1'b0;
      valid <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
`ifdef SHREG_CTRL_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      init  <= 1'b0;
      shen  <= 1'b0;
      valid <= '0;
      done  <= 1'b0;
      cap   <= 1'b0;
`ifdef SHREG_CTRL_PARITY_EN
      perr  <= 1'b0;
`endif
      if (cap) begin
        n_r <= n;
        d_r <= d;
      end
      case (state)
        IDLE: begin
          if (serIn) begin
            state <= INIT;
            init  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        INIT: begin
          state <= HDR;
          shen  <= 1'b1;
        end
        HDR: begin
          if (cnt_zero) begin
            cap <= 1'b1;
`ifdef SHREG_CTRL_PARITY_EN
            state <= PAR;
`else
            if (hdr_n == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PAY;
              valid <= port_onehot(hdr_d);
            end
`endif
          end else begin
            shen <= 1'b1;
          end
        end
`ifdef SHREG_CTRL_PARITY_EN
        PAR: begin
          // Even parity: the parity bit equals the XOR of the six header bits.
          if (serIn != ^{d, n}) begin
            state <= DONE;
            done  <= 1'b1;
            perr  <= 1'b1;
          end else if (n == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= PAY;
            valid <= port_onehot(d);
          end
        end
`endif
        PAY: begin
          if (cnt_zero) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // d_r is written on the capture edge itself, so read d directly then.
            valid <= port_onehot(cap ? d : d_r);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign serOut = valid & {NPORTS{serIn}};

  // The held length is kept for observation only; no datapath consumes it.
  logic unused_n_r;
  assign unused_n_r = ^n_r;

endmodule

// File: tb/tb_shreg_ctrl.sv
// tb/tb_shreg_ctrl.sv - directed self-checking bench for shreg_ctrl with its header shift register
module tb_shreg_ctrl;

`ifdef SHREG_CTRL_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b0;
  logic [3:0] n;
  logic [1:0] d;
  logic       shen, init, done, busy;
  logic [3:0] serOut, valid;
`ifdef SHREG_CTRL_PARITY_EN
  logic       perr;
`endif

  logic [5:0] sr = '0;
  int errs = 0;
  int checks = 0;

  logic [31:0] v_init, v_shen, v_done, v_busy, v_perr;
  logic [31:0] v_valid [4];
  logic [31:0] v_sout [4];

  always #5 clk = ~clk;

  // External header shift register
  always @(posedge clk) begin
    if (init) sr <= '0;
    else if (shen) sr <= {sr[4:0], serIn};
  end
  assign n = sr[3:0];
  assign d = sr[5:4];

  shreg_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .serIn  (serIn),
    .n      (n),
    .d      (d),
    .shen   (shen),
    .init   (init),
    .serOut (serOut),
    .valid  (valid),
    .done   (done),
`ifdef SHREG_CTRL_PARITY_EN
    .perr   (perr),
`endif
    .busy   (busy)
  );

  // serIn per cycle for a frame starting at cycle 'at' (parity bit correct when enabled)
  function automatic logic [63:0] mkseq(input logic [5:0] hdr, input logic [15:0] pay,
                                        input int npay, input int at);
    logic [63:0] s;
    s = '0;
    s[at] = 1'b1;
    for (int i = 0; i < 6; i++) s[at + 2 + i] = hdr[5 - i];
`ifdef SHREG_CTRL_PARITY_EN
    s[at + 8] = ^hdr;
`endif
    for (int i = 0; i < npay; i++) s[at + 8 + PX + i] = pay[i];
    return s;
  endfunction

  // Runs 32 cycles; cycle c lies between posedge c and posedge c+1.
  task automatic run(input logic [63:0] seq, input logic [31:0] rstv);
    for (int c = 0; c < 32; c++) begin
      serIn = seq[c];
      rst   = rstv[c];
      @(negedge clk);
      v_init[c] = init;
      v_shen[c] = shen;
      v_done[c] = done;
      v_busy[c] = busy;
`ifdef SHREG_CTRL_PARITY_EN
      v_perr[c] = perr;
`else
      v_perr[c] = 1'b0;
`endif
      for (int p = 0; p < 4; p++) begin
        v_valid[p][c] = valid[p];
        v_sout[p][c]  = serOut[p];
      end
      @(posedge clk);
      #1;
    end
    serIn = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({shen, init, done, busy, valid, serOut} !== 12'h0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 000", {shen, init, done, busy, valid, serOut});
    end
    serIn = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run(mkseq(6'b10_0011, 16'b101, 3, 0), 32'h0);
    checks++;
    if (v_init !== 32'h2) begin errs++; $display("FAIL t1_init: got %h want %h", v_init, 32'h2); end
    checks++;
    if (v_shen !== 32'hFC) begin errs++; $display("FAIL t1_shen: got %h want %h", v_shen, 32'hFC); end
    checks++;
    if (v_valid[2] !== (32'h7 << (8 + PX))) begin
      errs++; $display("FAIL t1_valid2: got %h want %h", v_valid[2], 32'h7 << (8 + PX));
    end
    checks++;
    if ((v_valid[0] | v_valid[1] | v_valid[3]) !== 32'h0) begin
      errs++; $display("FAIL t1_valid_other: got %h want 0", v_valid[0] | v_valid[1] | v_valid[3]);
    end
    checks++;
    if (v_sout[2] !== (32'h5 << (8 + PX))) begin
      errs++; $display("FAIL t1_serout2: got %h want %h", v_sout[2], 32'h5 << (8 + PX));
    end
    checks++;
    if (v_done !== (32'h1 << (11 + PX))) begin
      errs++; $display("FAIL t1_done: got %h want %h", v_done, 32'h1 << (11 + PX));
    end
    checks++;
    if (v_busy !== (((32'h1 << (12 + PX)) - 1) & ~32'h1)) begin
      errs++; $display("FAIL t1_busy: got %h want %h", v_busy, ((32'h1 << (12 + PX)) - 1) & ~32'h1);
    end
    checks++;
    if (v_perr !== 32'h0) begin errs++; $display("FAIL t1_perr: got %h want 0", v_perr); end
  endtask

  task automatic test_zero_len();
    run(mkseq(6'b01_0000, 16'h0, 0, 0), 32'h0);
    checks++;
    if ((v_valid[0] | v_valid[1] | v_valid[2] | v_valid[3]) !== 32'h0) begin
      errs++; $display("FAIL t2_valid: got %h want 0", v_valid[0] | v_valid[1] | v_valid[2] | v_valid[3]);
    end
    checks++;
    if (v_done !== (32'h1 << (8 + PX))) begin
      errs++; $display("FAIL t2_done: got %h want %h", v_done, 32'h1 << (8 + PX));
    end
    checks++;
    if (v_busy !== (((32'h1 << (9 + PX)) - 1) & ~32'h1)) begin
      errs++; $display("FAIL t2_busy: got %h want %h", v_busy, ((32'h1 << (9 + PX)) - 1) & ~32'h1);
    end
  endtask

  task automatic test_max_len();
    run(mkseq(6'b11_1111, 16'h2B6D, 15, 0), 32'h0);
    checks++;
    if (v_valid[3] !== (32'h7FFF << (8 + PX))) begin
      errs++; $display("FAIL t3_valid3: got %h want %h", v_valid[3], 32'h7FFF << (8 + PX));
    end
    checks++;
    if (v_sout[3] !== (32'h2B6D << (8 + PX))) begin
      errs++; $display("FAIL t3_serout3: got %h want %h", v_sout[3], 32'h2B6D << (8 + PX));
    end
    checks++;
    if (v_done !== (32'h1 << (23 + PX))) begin
      errs++; $display("FAIL t3_done: got %h want %h", v_done, 32'h1 << (23 + PX));
    end
    checks++;
    if ((v_valid[0] | v_valid[1] | v_valid[2]) !== 32'h0) begin
      errs++; $display("FAIL t3_valid_other: got %h want 0", v_valid[0] | v_valid[1] | v_valid[2]);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] seq;
    // rst during the 4th header bit (cycle 5); new start bit right after, at cycle 6
    seq = (mkseq(6'b11_0101, 16'h0, 5, 0) & 64'h3F) | mkseq(6'b10_0011, 16'b101, 3, 6);
    run(seq, 32'h20);
    checks++;
    if ({v_init[6], v_shen[6], v_done[6], v_busy[6], v_valid[0][6], v_valid[1][6],
         v_valid[2][6], v_valid[3][6]} !== 8'h0) begin
      errs++; $display("FAIL rst_cycle6_outputs: got %b want 0",
        {v_init[6], v_shen[6], v_done[6], v_busy[6], v_valid[0][6], v_valid[1][6], v_valid[2][6], v_valid[3][6]});
    end
    checks++;
    if (v_shen !== 32'h3F3C) begin errs++; $display("FAIL rst_shen: got %h want %h", v_shen, 32'h3F3C); end
    checks++;
    if (v_init !== 32'h82) begin errs++; $display("FAIL rst_init: got %h want %h", v_init, 32'h82); end
    checks++;
    if (v_done !== (32'h1 << (17 + PX))) begin
      errs++; $display("FAIL rst_done: got %h want %h", v_done, 32'h1 << (17 + PX));
    end
    checks++;
    if (v_valid[2] !== (32'h7 << (14 + PX))) begin
      errs++; $display("FAIL rst_valid2: got %h want %h", v_valid[2], 32'h7 << (14 + PX));
    end
    checks++;
    if (v_sout[2] !== (32'h5 << (14 + PX))) begin
      errs++; $display("FAIL rst_serout2: got %h want %h", v_sout[2], 32'h5 << (14 + PX));
    end
  endtask

  task automatic test_held_high();
    int he;
    logic [63:0] seq;
`ifdef SHREG_CTRL_PARITY_EN
    he = 9;   // header 11_1111 with parity bit 1 is a parity error
`else
    he = 23;
`endif
    seq = (64'h1 << (he + 1)) - 64'h1;
    run(seq, 32'h0);
    checks++;
    if (v_init !== 32'h2) begin errs++; $display("FAIL hold_init: got %h want %h", v_init, 32'h2); end
    checks++;
    if (v_done !== (32'h1 << he)) begin
      errs++; $display("FAIL hold_done: got %h want %h", v_done, 32'h1 << he);
    end
    checks++;
    if (v_busy !== (((32'h1 << (he + 1)) - 1) & ~32'h1)) begin
      errs++; $display("FAIL hold_busy: got %h want %h", v_busy, ((32'h1 << (he + 1)) - 1) & ~32'h1);
    end
`ifdef SHREG_CTRL_PARITY_EN
    checks++;
    if (v_valid[3] !== 32'h0) begin errs++; $display("FAIL hold_valid3: got %h want 0", v_valid[3]); end
    checks++;
    if (v_perr !== (32'h1 << 9)) begin errs++; $display("FAIL hold_perr: got %h want %h", v_perr, 32'h1 << 9); end
`else
    checks++;
    if (v_valid[3] !== (32'h7FFF << 8)) begin
      errs++; $display("FAIL hold_valid3: got %h want %h", v_valid[3], 32'h7FFF << 8);
    end
`endif
  endtask

`ifdef SHREG_CTRL_PARITY_EN
  task automatic test_parity_err();
    // correct parity for 10_0011 is 1; drive 0 instead
    run(mkseq(6'b10_0011, 16'b101, 3, 0) ^ (64'h1 << 8), 32'h0);
    checks++;
    if (v_perr !== (32'h1 << 9)) begin errs++; $display("FAIL par_perr: got %h want %h", v_perr, 32'h1 << 9); end
    checks++;
    if (v_done !== (32'h1 << 9)) begin errs++; $display("FAIL par_done: got %h want %h", v_done, 32'h1 << 9); end
    checks++;
    if ((v_valid[0] | v_valid[1] | v_valid[2] | v_valid[3]) !== 32'h0) begin
      errs++; $display("FAIL par_valid: got %h want 0", v_valid[0] | v_valid[1] | v_valid[2] | v_valid[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_max_len();
    test_mid_reset();
    test_held_high();
`ifdef SHREG_CTRL_PARITY_EN
    test_parity_err();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
